dtree_event_buffer: RTL and testbench
=====================================

// Module: dtree_event_buffer
// PURPOSE
//   Downstream stage of dtree. Captures each classification result (level, path) on out_valid.
//   Tags each result with a sample-index timestamp and buffers it in a FIFO.
//   Keeps per-level saturating spike counts.
//   Presents buffered events on a valid/ready stream for the readout/host interface,
//   decoupling bursty classifier output from a stalling consumer.
// PARAMETERS
//   DEPTH       16  FIFO entries; power of two, >=2
//   TS_WIDTH    24  timestamp width (cycles since reset release), wraps
//   CNT_WIDTH   16  width of each per-level spike counter, saturating
//   DROP_WIDTH  8   width of dropped-event counter, saturating
// PORTS
//   clk          in   1                clock, one sample per cycle
//   reset        in   1                synchronous, active-high
//   in_level     in   2                dtree level of the result
//   in_path      in   2                dtree path bits of the result
//   in_valid     in   1                dtree out_valid; one result per asserted cycle
//   clear        in   1                sync clear of counters, drop_count, overflow
//   ev_timestamp out  TS_WIDTH         timestamp of head event
//   ev_level     out  2                level of head event
//   ev_path      out  2                path of head event
//   ev_valid     out  1                head event valid
//   ev_ready     in   1                consumer accepts head when ev_valid&ev_ready
//   level_count  out  4*CNT_WIDTH      per-level counts; [k*CNT_WIDTH +: CNT_WIDTH] = level k
//   drop_count   out  DROP_WIDTH       events lost to full FIFO
//   overflow     out  1                sticky: at least one drop since reset/clear
//   fill         out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset (sync, high): all outputs 0, FIFO emptied, timestamp=0. Reset mid-stream discards
//     buffered events; in_valid during reset is ignored.
//   Timestamp: ts increments by 1 every cycle reset is low; wraps 2^TS_WIDTH-1 -> 0.
//     An event is stamped with the ts value of the cycle in which in_valid is high.
//   Push: in_valid=1 and (fill<DEPTH or pop this cycle) -> write {ts,in_level,in_path}.
//   Pop: ev_valid&ev_ready. Head outputs are registered. ev_valid and head fields must not
//     change while ev_valid=1 and ev_ready=0.
//   Latency: push into an empty FIFO at cycle N -> ev_valid=1 at N+1 with that event.
//     There is no combinational in->out path.
//   Simultaneous push+pop: allowed at any fill, including full (DEPTH). fill unchanged.
//     Order strictly FIFO.
//   Full, no pop, in_valid=1: event dropped. drop_count += 1 (saturates at all-ones).
//     overflow <= 1. Counters still increment (the count reflects classified spikes, not buffered).
//   Counters: on every in_valid, level_count[in_level] += 1, saturating at 2^CNT_WIDTH-1.
//   clear: zeroes level_count, drop_count, overflow next cycle. FIFO and ts unaffected.
//     clear and in_valid in the same cycle: clear wins for counters; the event is still buffered.
//     If the FIFO is full, drop accounting is suppressed that cycle (cleared values win).
//   Empty: ev_valid=0. ev_ready is ignored and head fields hold their last value.
//   fill: exact occupancy after each clock edge. Range 0..DEPTH.
// STRUCTURE
//   dtree_pkg: LEVEL_W=2, PATH_W=2, NUM_LEVELS=4, and the event record layout
//     {ts,level,path} with width EV_W = TS_WIDTH+4.
//   Sub-module sync_fifo (WIDTH, DEPTH): pointer-based with extra wrap bit, registered
//     read data, push/pop/full/empty/fill.
//   Top holds the ts counter, the saturating counters and the drop/overflow logic.
// TESTING
//   1. Reset 20 cycles, then in_valid at ts=5 with level=2, path=2'b01, ev_ready=1
//      -> next cycle ev_valid=1, ev_timestamp=5, ev_level=2, ev_path=01; then ev_valid=0.
//   2. ev_ready=0, push 16 events (levels 0,1,2,3 repeating), then a 17th
//      -> fill=16, drop_count=1, overflow=1, level_count={5,4,4,4}.
//      Drain shows the first 16 events in order.
//   3. Full FIFO, in_valid=1 and ev_ready=1 together -> no drop; fill stays 16.
//      Popped event = oldest; new event appears last.
//   4. Hold ev_ready=0 for 10 cycles with ev_valid=1 -> head fields are stable every cycle.
//   5. CNT_WIDTH=4, 20 events at level 3 -> count3=15, saturated.
//      Pulse clear on a cycle with an event -> counts=0, drop_count=0, overflow=0,
//      and the event is still delivered.
//   6. Assert reset with 7 events buffered -> next cycle fill=0, ev_valid=0, all outputs 0.
//      After release, ts restarts from 0.

Source files
------------

// File: rtl/dtree_event_buffer_pkg.sv
// Shared widths and the classification record carried by dtree events.
// An event is stored as {timestamp, level, path}.
package dtree_event_buffer_pkg;
  localparam int LEVEL_W    = 2;
  localparam int PATH_W     = 2;
  localparam int NUM_LEVELS = 4;

  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    logic [PATH_W-1:0]  path;
  } class_t;

  function automatic int ev_width(input int ts_width);
    return ts_width + LEVEL_W + PATH_W;
  endfunction
endpackage

// File: rtl/dtree_event_buffer_if.sv
// Valid/ready event stream from the buffer head to the readout consumer.
interface dtree_event_buffer_if
  import dtree_event_buffer_pkg::*;
#(
  parameter int TS_WIDTH = 24
);
  logic [TS_WIDTH-1:0] ev_timestamp;
  logic [LEVEL_W-1:0]  ev_level;
  logic [PATH_W-1:0]   ev_path;
  logic                ev_valid;
  logic                ev_ready;

  modport master (output ev_timestamp, ev_level, ev_path, ev_valid, input ev_ready);
  modport slave  (input ev_timestamp, ev_level, ev_path, ev_valid, output ev_ready);
endinterface

// File: rtl/dtree_event_buffer_sync_fifo.sv
// Pointer FIFO (extra wrap bit) with a registered head word and registered valid;
// the head register is loaded with bypass when the next head is being written.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_rdata;
  logic             r_vld;

  logic [AW:0]      w_fill;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_wptr_nxt;
  logic [AW:0]      w_rptr_nxt;
  logic [AW:0]      w_fill_nxt;
  logic [AW-1:0]    w_head_idx;

  assign w_fill     = r_wptr - r_rptr;
  assign w_full     = (w_fill == FULL_CNT);
  assign w_pop      = i_pop & r_vld;
  assign w_push     = i_push & (~w_full | w_pop);
  assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);
  assign w_fill_nxt = w_wptr_nxt - w_rptr_nxt;
  assign w_head_idx = w_rptr_nxt[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  // Head register: refreshed whenever the FIFO stays non-empty, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_vld  <= (w_fill_nxt != '0);
      if (w_fill_nxt != '0) begin
        if (w_push && (w_head_idx == r_wptr[AW-1:0])) r_rdata <= i_wdata;
        else                                          r_rdata <= r_mem[w_head_idx];
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = w_full;
  assign o_empty = ~r_vld;
  assign o_fill  = w_fill;
endmodule

// File: rtl/dtree_event_buffer.sv
// Timestamps dtree classification results, buffers them for a stalling consumer,
// and keeps saturating per-level spike counts plus drop/overflow accounting.
module dtree_event_buffer
  import dtree_event_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 24,
  parameter int CNT_WIDTH  = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LEVEL_W-1:0]              in_level,
  input  logic [PATH_W-1:0]               in_path,
  input  logic                            in_valid,
  input  logic                            clear,
  dtree_event_buffer_if.master            ev,
  output logic [NUM_LEVELS*CNT_WIDTH-1:0] level_count,
  output logic [DROP_WIDTH-1:0]           drop_count,
  output logic                            overflow,
  output logic [$clog2(DEPTH):0]          fill
);
  localparam int EV_W = TS_WIDTH + LEVEL_W + PATH_W;

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DROP_WIDTH-1:0] sat_drop(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [TS_WIDTH-1:0]  r_ts;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_LEVELS];
  logic [DROP_WIDTH-1:0] r_drop;
  logic                 r_ovf;

  logic [EV_W-1:0]      w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_pop  = ~w_empty & ev.ev_ready;
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({r_ts, in_level, in_path}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (fill)
  );

  // Counters see every classified spike; clear takes priority over counting and drops.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < NUM_LEVELS; k++) r_cnt[k] <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (in_valid) r_cnt[in_level] <= sat_cnt(r_cnt[in_level]);
      if (w_drop) begin
        r_drop <= sat_drop(r_drop);
        r_ovf  <= 1'b1;
      end
    end
  end

  always_comb begin
    level_count = '0;
    for (int k = 0; k < NUM_LEVELS; k++) level_count[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
  end

  assign drop_count      = r_drop;
  assign overflow        = r_ovf;
  assign ev.ev_valid     = ~w_empty;
  assign ev.ev_timestamp = w_head[EV_W-1 -: TS_WIDTH];
  assign ev.ev_level     = w_head[LEVEL_W+PATH_W-1 -: LEVEL_W];
  assign ev.ev_path      = w_head[PATH_W-1:0];
endmodule

// File: tb/tb_dtree_event_buffer.sv
// Directed bench for dtree_event_buffer: a default instance plus a 4-bit-counter
// instance driven with identical stimulus.
module tb_dtree_event_buffer;
  import dtree_event_buffer_pkg::*;

  localparam int TSW   = 24;
  localparam int DEPTH = 16;
  localparam int EVW   = TSW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, in_valid, ev_ready;
  logic [1:0] in_level, in_path;

  dtree_event_buffer_if #(.TS_WIDTH(TSW)) bus ();
  dtree_event_buffer_if #(.TS_WIDTH(TSW)) bus4 ();
  assign bus.ev_ready  = ev_ready;
  assign bus4.ev_ready = ev_ready;

  logic [63:0] lc;
  logic [15:0] lc4;
  logic [7:0]  dc, dc4;
  logic        ov, ov4;
  logic [4:0]  fill, fill4;

  dtree_event_buffer #(.DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(16), .DROP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_level(in_level), .in_path(in_path), .in_valid(in_valid),
    .clear(clear), .ev(bus), .level_count(lc), .drop_count(dc), .overflow(ov), .fill(fill));

  dtree_event_buffer #(.DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(4), .DROP_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .in_level(in_level), .in_path(in_path), .in_valid(in_valid),
    .clear(clear), .ev(bus4), .level_count(lc4), .drop_count(dc4), .overflow(ov4), .fill(fill4));

  int n_chk  = 0;
  int n_pass = 0;
  logic [EVW-1:0] q[$];
  int unsigned tb_ts = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock: model tracks queue contents and the timestamp counter.
  task automatic tick();
    bit pop, push;
    logic [EVW-1:0] ent;
    pop  = (q.size() > 0) && ev_ready;
    push = in_valid && !reset && ((q.size() < DEPTH) || pop);
    ent  = {tb_ts[TSW-1:0], in_level, in_path};
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      tb_ts = 0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ent);
      tb_ts++;
    end
  endtask

  task automatic check_head(input string tag);
    if (q.size() > 0) begin
      chk({tag, "_vld"}, 64'(bus.ev_valid), 64'd1);
      chk({tag, "_ev"}, 64'({bus.ev_timestamp, bus.ev_level, bus.ev_path}), 64'(q[0]));
    end else begin
      chk({tag, "_vld"}, 64'(bus.ev_valid), 64'd0);
    end
  endtask

  task automatic drain(input int n);
    ev_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_head($sformatf("drain%0d", i));
      tick();
    end
    ev_ready = 1'b0;
    chk("drain_fill", 64'(fill), 64'd0);
    chk("drain_vld", 64'(bus.ev_valid), 64'd0);
  endtask

  task automatic push_n(input int n, input logic [1:0] lvl, input logic [1:0] pth);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_level = lvl; in_path = pth;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; ev_ready = 1'b0;
    in_level = '0; in_path = '0;
    repeat (20) tick();
    chk("rst_vld", 64'(bus.ev_valid), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_lc", lc, 64'd0);
    chk("rst_drop", 64'(dc), 64'd0);
    chk("rst_ovf", 64'(ov), 64'd0);
    chk("rst_ts", 64'(bus.ev_timestamp), 64'd0);

    // Test 1: single event at ts=5
    reset = 1'b0;
    repeat (5) tick();
    in_valid = 1'b1; in_level = 2'd2; in_path = 2'b01; ev_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_vld", 64'(bus.ev_valid), 64'd1);
    chk("t1_ts", 64'(bus.ev_timestamp), 64'd5);
    chk("t1_lvl", 64'(bus.ev_level), 64'd2);
    chk("t1_path", 64'(bus.ev_path), 64'd1);
    tick();
    chk("t1_empty", 64'(bus.ev_valid), 64'd0);
    chk("t1_hold_ts", 64'(bus.ev_timestamp), 64'd5);

    // Test 2: fill to 16 then overflow by one
    ev_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_level = 2'(i % 4); in_path = 2'((i / 4) % 4);
      tick();
    end
    in_valid = 1'b1; in_level = 2'd0; in_path = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("t2_fill", 64'(fill), 64'd16);
    chk("t2_drop", 64'(dc), 64'd1);
    chk("t2_ovf", 64'(ov), 64'd1);
    chk("t2_lc0", 64'(lc[15:0]), 64'd5);
    chk("t2_lc1", 64'(lc[31:16]), 64'd4);
    chk("t2_lc2", 64'(lc[47:32]), 64'd4);
    chk("t2_lc3", 64'(lc[63:48]), 64'd4);
    chk("t2_head_ts", 64'(bus.ev_timestamp), 64'd8);

    // Test 3: push and pop together while full
    in_valid = 1'b1; in_level = 2'd1; in_path = 2'd3; ev_ready = 1'b1;
    tick();
    in_valid = 1'b0; ev_ready = 1'b0;
    chk("t3_fill", 64'(fill), 64'd16);
    chk("t3_drop", 64'(dc), 64'd1);
    chk("t3_head_ts", 64'(bus.ev_timestamp), 64'd9);

    // Test 4: stalled head must hold
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t4_vld%0d", i), 64'(bus.ev_valid), 64'd1);
      chk($sformatf("t4_head%0d", i), 64'({bus.ev_timestamp, bus.ev_level, bus.ev_path}),
          64'({24'd9, 2'd1, 2'd0}));
    end
    chk("t4_tail", 64'(q[DEPTH-1]), 64'({24'd25, 2'd1, 2'd3}));
    drain(16);

    // Test 5: saturation in the 4-bit instance, then clear together with an event
    ev_ready = 1'b1;
    push_n(20, 2'd3, 2'd1);
    chk("t5_lc3_sat", 64'(lc4[15:12]), 64'd15);
    chk("t5_lc3_wide", 64'(lc[63:48]), 64'd24);
    chk("t5_fill", 64'(fill), 64'd1);
    clear = 1'b1; in_valid = 1'b1; in_level = 2'd0; in_path = 2'd2;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_lc", lc, 64'd0);
    chk("t5_lc4", 64'(lc4), 64'd0);
    chk("t5_drop", 64'(dc), 64'd0);
    chk("t5_ovf", 64'(ov), 64'd0);
    chk("t5_drop4", 64'(dc4), 64'd0);
    chk("t5_ovf4", 64'(ov4), 64'd0);
    chk("t5_ev_vld", 64'(bus.ev_valid), 64'd1);
    chk("t5_ev_lvl", 64'(bus.ev_level), 64'd0);
    chk("t5_ev_path", 64'(bus.ev_path), 64'd2);
    tick();
    ev_ready = 1'b0;
    chk("t5_empty", 64'(bus.ev_valid), 64'd0);

    // Clear on a full FIFO suppresses drop accounting
    push_n(17, 2'd2, 2'd2);
    chk("fc_drop_pre", 64'(dc), 64'd1);
    clear = 1'b1; in_valid = 1'b1; in_level = 2'd3; in_path = 2'd0;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("fc_fill", 64'(fill), 64'd16);
    chk("fc_drop", 64'(dc), 64'd0);
    chk("fc_ovf", 64'(ov), 64'd0);
    chk("fc_lc", lc, 64'd0);
    drain(16);

    // Test 6: reset with 7 buffered events
    push_n(7, 2'd1, 2'd2);
    chk("t6_fill7", 64'(fill), 64'd7);
    reset = 1'b1; in_valid = 1'b1;
    tick();
    chk("t6_fill", 64'(fill), 64'd0);
    chk("t6_fill4", 64'(fill4), 64'd0);
    chk("t6_vld", 64'(bus.ev_valid), 64'd0);
    chk("t6_vld4", 64'(bus4.ev_valid), 64'd0);
    chk("t6_head", 64'({bus.ev_timestamp, bus.ev_level, bus.ev_path}), 64'd0);
    chk("t6_lc", lc, 64'd0);
    chk("t6_drop", 64'(dc), 64'd0);
    chk("t6_ovf", 64'(ov), 64'd0);
    reset = 1'b0; in_valid = 1'b1; in_level = 2'd1; in_path = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("t6_vld_after", 64'(bus.ev_valid), 64'd1);
    chk("t6_ts_restart", 64'(bus.ev_timestamp), 64'd0);
    chk("t6_lc1", 64'(lc[31:16]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
